// File: rtl/sort_pkg.sv
// sort_pkg: shared sizing, pad value, frame type and collector FSM states for the max-sort pipeline.
//   M       samples per frame (slots in a sort frame)
//   N       sample width in bits
//   CNT_W   width of a frame's real-sample count (0..M)
//   PAD_VAL minimum sample value, so padding never wins a max sort
package sort_pkg;

    localparam int M = 8;
    localparam int N = 16;
    localparam int CNT_W = $clog2(M + 1);
    localparam logic [N-1:0] PAD_VAL = '0;

    typedef logic [M-1:0][N-1:0] frame_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/sort_frame_collector.sv
// sort_frame_collector: packs a serial valid/ready sample stream into padded M-slot frames for the sort stage.
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   upstream sample handshake; s_data sample, s_last closes the frame early
//   o_chi             frame, slot k holds the k-th accepted sample, unused slots hold PAD_VAL
//   o_count           number of real samples in o_chi (1..M)
//   o_valid/o_ready   downstream frame handshake; o_chi/o_count hold while o_valid && !o_ready
module sort_frame_collector #(
    parameter int M = sort_pkg::M,
    parameter int N = sort_pkg::N,
    parameter logic [N-1:0] PAD_VAL = N'(sort_pkg::PAD_VAL)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [N-1:0]              s_data,
    input  logic                      s_last,
    output logic [M-1:0][N-1:0]       o_chi,
    output logic [$clog2(M+1)-1:0]    o_count,
    output logic                      o_valid,
    input  logic                      o_ready
);

    import sort_pkg::*;

    localparam int IW = $clog2(M);
    localparam int CW = $clog2(M + 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [M-1:0][N-1:0]   fill_q, fill_d, merged;
    logic [M-1:0][N-1:0]   chi_q, chi_d;
    logic [CW-1:0]         cnt_q, cnt_d, pend_q, pend_d;
    logic                  vld_q, vld_d;
    logic                  accept, done, slot_free;
    logic [CW-1:0]         cur_cnt;

    assign accept    = s_valid && s_ready;
    assign done      = accept && (s_last || wr_idx_q == IW'(M - 1));
    assign slot_free = !vld_q || o_ready;
    assign cur_cnt   = CW'(wr_idx_q) + CW'(1);

    // fill buffer with the sample being accepted this cycle already in place
    always_comb begin
        merged = fill_q;
        merged[wr_idx_q] = s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // a completed frame parks in the fill buffer (HOLD) only when the output register is still occupied
    always_comb begin
        state_d = (state_q == FILL) ? ((done && !slot_free) ? HOLD : FILL)
                                    : (slot_free ? FILL : HOLD);
    end

    always_comb begin
        s_ready = (state_q == FILL) && rst_n;
    end

    always_comb begin
        wr_idx_d = wr_idx_q;
        fill_d   = fill_q;
        chi_d    = chi_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        // a handshake clears valid unless a new frame is loaded on the same edge below
        vld_d    = vld_q && !o_ready;
        if (state_q == HOLD) begin
            if (slot_free) begin
                chi_d    = fill_q;
                cnt_d    = pend_q;
                vld_d    = 1'b1;
                fill_d   = {M{PAD_VAL}};
                wr_idx_d = '0;
            end
        end else if (done) begin
            if (slot_free) begin
                chi_d    = merged;
                cnt_d    = cur_cnt;
                vld_d    = 1'b1;
                fill_d   = {M{PAD_VAL}};
                wr_idx_d = '0;
            end else begin
                fill_d   = merged;
                pend_d   = cur_cnt;
            end
        end else if (accept) begin
            fill_d   = merged;
            wr_idx_d = wr_idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            fill_q   <= {M{PAD_VAL}};
            chi_q    <= {M{PAD_VAL}};
            cnt_q    <= '0;
            pend_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            fill_q   <= fill_d;
            chi_q    <= chi_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            vld_q    <= vld_d;
        end
    end

    assign o_chi   = chi_q;
    assign o_count = cnt_q;
    assign o_valid = vld_q;

endmodule

// File: tb/tb_sort_frame_collector.sv
// tb_sort_frame_collector: directed table, backpressure/reset sequences and a randomised scoreboard for sort_frame_collector.
module tb_sort_frame_collector;

    localparam int M  = 4;
    localparam int N  = 8;
    localparam int CW = $clog2(M + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [N-1:0]        s_data = '0;
    logic                s_last = 1'b0;
    logic [M-1:0][N-1:0] o_chi;
    logic [CW-1:0]       o_count;
    logic                o_valid;
    logic                o_ready = 1'b0;

    sort_frame_collector #(.M(M), .N(N), .PAD_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .o_chi(o_chi), .o_count(o_count), .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int total_n = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        e_sr;
        logic        e_ov;
        logic        e_chk;
        logic [31:0] e_chi;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    logic [M-1:0][N-1:0] bld;
    int                  bcnt = 0;
    logic [31:0]         exp_chi[$];
    int                  exp_cnt[$];
    logic                prev_hold = 1'b0;
    logic [31:0]         prev_chi;
    logic [CW-1:0]       prev_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                       input logic e_sr, input logic e_ov, input logic e_chk,
                       input logic [31:0] e_chi, input logic [2:0] e_cnt);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r;
        t.e_sr = e_sr; t.e_ov = e_ov; t.e_chk = e_chk; t.e_chi = e_chi; t.e_cnt = e_cnt;
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        s_valid = v; s_data = d; s_last = l; o_ready = r;
    endtask

    task automatic expect_out(input string name, input logic sr, input logic ov, input logic [31:0] chi, input logic [2:0] cnt);
        chk({name, ".s_ready"}, 64'(s_ready), 64'(sr));
        chk({name, ".o_valid"}, 64'(o_valid), 64'(ov));
        chk({name, ".o_chi"}, 64'(o_chi), 64'(chi));
        chk({name, ".o_count"}, 64'(o_count), 64'(cnt));
    endtask

    // one scoreboard cycle: inputs are already driven and outputs are stable
    task automatic sb_eval();
        if (prev_hold) begin
            chk("rnd_hold.o_valid", 64'(o_valid), 64'(1'b1));
            chk("rnd_hold.o_chi", 64'(o_chi), 64'(prev_chi));
            chk("rnd_hold.o_count", 64'(o_count), 64'(prev_cnt));
        end
        if (o_valid && o_ready) begin
            if (exp_chi.size() == 0) begin
                chk("rnd_unexpected_frame", 64'(o_chi), 64'hDEAD_BEEF_0000_0000);
            end else begin
                chk("rnd.o_chi", 64'(o_chi), 64'(exp_chi[0]));
                chk("rnd.o_count", 64'(o_count), 64'(exp_cnt[0]));
                void'(exp_chi.pop_front());
                void'(exp_cnt.pop_front());
            end
        end
        if (s_valid && s_ready) begin
            bld[bcnt] = s_data;
            bcnt++;
            if (bcnt == M || s_last) begin
                exp_chi.push_back(32'(bld));
                exp_cnt.push_back(bcnt);
                bld = '0;
                bcnt = 0;
            end
        end
        prev_hold = o_valid && !o_ready;
        prev_chi = 32'(o_chi);
        prev_cnt = o_count;
    endtask

    initial begin
        // power-on reset
        step();
        step();
        expect_out("por", 1'b0, 1'b0, 32'h0, 3'd0);
        rst_n = 1'b1;
        #1;
        chk("por_release.s_ready", 64'(s_ready), 64'(1'b1));

        // streaming, short frame, ignored s_last, s_last on slot 3, simultaneous handshake+load
        add(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201, 3'd4);
        add(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h08070605, 3'd4);
        add(1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000B0A0, 3'd2);
        add(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4);
        add(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        add(1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h88776655, 3'd4);
        add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 3'd4);
        add(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 3'd4);
        add(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 3'd4);
        add(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201, 3'd4);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            step();
            chk($sformatf("vec%0d.s_ready", i), 64'(s_ready), 64'(tbl[i].e_sr));
            chk($sformatf("vec%0d.o_valid", i), 64'(o_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_chk) begin
                chk($sformatf("vec%0d.o_chi", i), 64'(o_chi), 64'(tbl[i].e_chi));
                chk($sformatf("vec%0d.o_count", i), 64'(o_count), 64'(tbl[i].e_cnt));
            end
        end

        // backpressure: frame 1 held, frame 2 parks in HOLD
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
            chk($sformatf("bp_fill%0d.s_ready", i), 64'(s_ready), 64'(1'b1));
            step();
        end
        expect_out("bp_hold", 1'b0, 1'b1, 32'h24232221, 3'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h29, 1'b0, 1'b0);
            step();
            expect_out($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 32'h24232221, 3'd4);
        end
        drive(1'b1, 8'h29, 1'b0, 1'b1);
        step();
        expect_out("bp_xfer2", 1'b1, 1'b1, 32'h28272625, 3'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h29 + i), 1'b0, 1'b0);
            step();
        end
        expect_out("bp_hold3", 1'b0, 1'b1, 32'h28272625, 3'd4);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        expect_out("bp_xfer3", 1'b1, 1'b1, 32'h2C2B2A29, 3'd4);
        step();
        chk("bp_drain.o_valid", 64'(o_valid), 64'(1'b0));

        // reset mid-operation: pending output frame and partial fill are both discarded
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
            step();
        end
        chk("pre_rst.o_valid", 64'(o_valid), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst", 1'b0, 1'b0, 32'h0, 3'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h51 + i), 1'b0, 1'b1);
            step();
        end
        expect_out("post_rst", 1'b1, 1'b1, 32'h54535251, 3'd4);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        chk("post_rst_drain.o_valid", 64'(o_valid), 64'(1'b0));

        // randomised traffic against a frame scoreboard
        bld = '0;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
            sb_eval();
            step();
        end
        for (int c = 0; c < 40; c++) begin
            drive(bcnt != 0, 8'($urandom), 1'b1, 1'b1);
            sb_eval();
            step();
        end
        chk("rnd_all_frames_seen", 64'(exp_chi.size()), 64'd0);
        chk("rnd_no_partial", 64'(bcnt), 64'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
